// File: rtl/cnn_window_pkg.sv
// Shared types and constants for the multi-channel sliding-window buffer.
// Optional build macro used by this design family: CNN_WINDOW_ZERO_FLUSH_EN.
package cnn_window_pkg;

  // Default geometry: 12-bit samples, 5-tap window, single channel.
  localparam int DEF_IN_WIDTH = 12;
  localparam int DEF_N        = 5;
  localparam int DEF_CH       = 1;
  localparam int DEF_STRIDE_W = 3;

  // Controller state, kept as a plain vector so older tools and dumps read it directly.
  typedef logic [0:0] state_t;
  localparam state_t ST_FILL   = 1'b0;
  localparam state_t ST_STEADY = 1'b1;

  // LSB position of tap k / channel c inside the flattened window bus.
  function automatic int tap_lsb(input int k, input int c, input int ch, input int width);
    return (k * ch + c) * width;
  endfunction

endpackage

// File: rtl/cnn_window_ctrl.sv
// Window controller: fill tracking, stride pacing, out_valid / in_ready
// handshake, and the shift enable for the tap datapath.
module cnn_window_ctrl
  import cnn_window_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int STRIDE_W = DEF_STRIDE_W,
  parameter int CNT_W    = $clog2(N + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic [STRIDE_W-1:0] stride,
  input  logic                in_valid,
  input  logic                out_ready,
  output logic                in_ready,
  output logic                out_valid,
  output logic [CNT_W-1:0]    fill_cnt,
  output logic                shift_en
);

  state_t              state;
  logic [STRIDE_W-1:0] stride_reg;
  logic [STRIDE_W-1:0] stride_cnt;
  logic                accept;

  // A held window blocks new samples, which is what keeps x_out stable.
  assign in_ready = !out_valid || out_ready;
  // A flush cycle swallows any sample presented alongside it.
  assign accept   = in_valid && in_ready && !flush;
  assign shift_en = accept;

  // Fill/stride state machine and window strobe.
  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_FILL;
      fill_cnt   <= '0;
      out_valid  <= 1'b0;
      stride_reg <= STRIDE_W'(1);
      stride_cnt <= '0;
    end else if (flush) begin
      state      <= ST_FILL;
      fill_cnt   <= '0;
      out_valid  <= 1'b0;
      stride_cnt <= '0;
      // Stride 0 would never emit; treat it as every sample.
      stride_reg <= (stride == '0) ? STRIDE_W'(1) : stride;
    end else if (state == ST_FILL) begin
      if (accept) begin
        fill_cnt <= fill_cnt + CNT_W'(1);
        if (fill_cnt == CNT_W'(N - 1)) begin
          out_valid  <= 1'b1;
          stride_cnt <= '0;
          state      <= ST_STEADY;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end else begin
      // Steady state: fill_cnt stays saturated at N.
      if (accept) begin
        if (stride_cnt == stride_reg - STRIDE_W'(1)) begin
          out_valid  <= 1'b1;
          stride_cnt <= '0;
        end else begin
          out_valid  <= 1'b0;
          stride_cnt <= stride_cnt + STRIDE_W'(1);
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cnn_window_buffer.sv
// Multi-channel sliding-window shift buffer feeding the MAC array.
// Build option: define CNN_WINDOW_ZERO_FLUSH_EN to clear all taps on flush;
// without it the taps keep stale data across flush and out_valid alone
// qualifies the window.
module cnn_window_buffer
  import cnn_window_pkg::*;
#(
  parameter  int IN_WIDTH = DEF_IN_WIDTH,
  parameter  int N        = DEF_N,
  parameter  int CH       = DEF_CH,
  parameter  int STRIDE_W = DEF_STRIDE_W,
  localparam int CNT_W    = $clog2(N + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [STRIDE_W-1:0]      stride,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CH*IN_WIDTH-1:0]   x_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CH*N*IN_WIDTH-1:0] x_out,
  output logic [CNT_W-1:0]         fill_cnt
);

  localparam int SW = CH * IN_WIDTH;

  logic          shift_en;
  logic [SW-1:0] tap_q [N];

  cnn_window_ctrl #(
    .N        (N),
    .STRIDE_W (STRIDE_W),
    .CNT_W    (CNT_W)
  ) u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .stride    (stride),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .fill_cnt  (fill_cnt),
    .shift_en  (shift_en)
  );

  for (genvar k = 0; k < N; k++) begin : g_tap
    logic [SW-1:0] q;
    logic [SW-1:0] d;

    // Tap 0 takes the new sample; every other tap takes its younger neighbour.
    if (k == 0) begin : g_head
      assign d = x_in;
    end else begin : g_body
      assign d = tap_q[k-1];
    end

    // Tap register: shifts only on an accepted sample.
    // NOTE: the taps are reset because downstream sees x_out directly and
    // expects zeros out of reset; a pure data RAM would not need this.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q <= '0;
`ifdef CNN_WINDOW_ZERO_FLUSH_EN
      end else if (flush) begin
        q <= '0;
`endif
      end else if (shift_en) begin
        q <= d;
      end
    end

    assign tap_q[k] = q;

    for (genvar c = 0; c < CH; c++) begin : g_ch
      assign x_out[tap_lsb(k, c, CH, IN_WIDTH) +: IN_WIDTH] = q[c*IN_WIDTH +: IN_WIDTH];
    end
  end

endmodule

// File: tb/tb_cnn_window_buffer.sv
// Directed self-checking bench for cnn_window_buffer (N=5, CH=2, 12-bit).
// Also checks zero-on-flush when built with CNN_WINDOW_ZERO_FLUSH_EN.
module tb_cnn_window_buffer;

  localparam int IN_WIDTH = 12;
  localparam int N        = 5;
  localparam int CH       = 2;
  localparam int STRIDE_W = 3;
  localparam int CNT_W    = $clog2(N + 1);

  logic                     clk;
  logic                     rst_n;
  logic                     flush;
  logic [STRIDE_W-1:0]      stride;
  logic                     in_valid;
  logic                     in_ready;
  logic [CH*IN_WIDTH-1:0]   x_in;
  logic                     out_valid;
  logic                     out_ready;
  logic [CH*N*IN_WIDTH-1:0] x_out;
  logic [CNT_W-1:0]         fill_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int mdl [N];  // ch0 value per tap, 0 = newest; ch1 is always ch0 + 100

  cnn_window_buffer #(
    .IN_WIDTH (IN_WIDTH),
    .N        (N),
    .CH       (CH),
    .STRIDE_W (STRIDE_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .stride    (stride),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_out     (x_out),
    .fill_cnt  (fill_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Window whose newest ch0 sample is s: taps s, s-1, ... and ch1 = ch0 + 100.
  function automatic logic [127:0] win(input int s);
    logic [127:0] w;
    w = '0;
    for (int k = 0; k < N; k++) begin
      w[(k*CH+0)*IN_WIDTH +: IN_WIDTH] = 12'(s - k);
      w[(k*CH+1)*IN_WIDTH +: IN_WIDTH] = 12'(s - k + 100);
    end
    return w;
  endfunction

  function automatic logic [127:0] model_win();
    logic [127:0] w;
    w = '0;
    for (int k = 0; k < N; k++) begin
      w[(k*CH+0)*IN_WIDTH +: IN_WIDTH] = 12'(mdl[k]);
      w[(k*CH+1)*IN_WIDTH +: IN_WIDTH] = (mdl[k] == 0) ? 12'd0 : 12'(mdl[k] + 100);
    end
    return w;
  endfunction

  function automatic void model_shift(input int s);
    for (int k = N - 1; k > 0; k--) mdl[k] = mdl[k-1];
    mdl[0] = s;
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < N; k++) mdl[k] = 0;
  endfunction

  // One accepted sample; returns 1 time unit after the capturing edge.
  task automatic push(input int s);
    in_valid = 1'b1;
    x_in     = {12'(s + 100), 12'(s)};
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    model_shift(s);
  endtask

  task automatic do_flush(input logic [STRIDE_W-1:0] s);
    flush  = 1'b1;
    stride = s;
    @(posedge clk);
    #1;
    flush = 1'b0;
`ifdef CNN_WINDOW_ZERO_FLUSH_EN
    model_clear();
`endif
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    stride    = 3'd1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x_in      = '0;
    model_clear();

    // Reset state
    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_fill_cnt", fill_cnt, 0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_x_out", x_out, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Stride 1 straight out of reset: windows from sample 5 onward
    for (int s = 1; s <= 7; s++) begin
      push(s);
      check($sformatf("s1_valid_%0d", s), out_valid, s >= 5);
      check($sformatf("s1_fill_%0d", s), fill_cnt, (s >= 5) ? 5 : s);
      if (s >= 5) check($sformatf("s1_win_%0d", s), x_out, win(s));
    end

    // Stride 2: windows only for samples 5, 7, 9
    do_flush(3'd2);
    check("f2_fill", fill_cnt, 0);
    check("f2_valid", out_valid, 1'b0);
    for (int s = 1; s <= 9; s++) begin
      push(s);
      check($sformatf("s2_valid_%0d", s), out_valid, (s == 5) || (s == 7) || (s == 9));
      check($sformatf("s2_fill_%0d", s), fill_cnt, (s >= 5) ? 5 : s);
      if (s == 5 || s == 7 || s == 9) check($sformatf("s2_win_%0d", s), x_out, win(s));
    end

    // Backpressure: hold window {5..1} for 4 cycles with sample 6 waiting
    do_flush(3'd1);
    for (int s = 1; s <= 5; s++) push(s);
    check("bp_first_valid", out_valid, 1'b1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    x_in      = {12'd106, 12'd6};
    #1;
    check("bp_in_ready_low", in_ready, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp_hold_valid_%0d", i), out_valid, 1'b1);
      check($sformatf("bp_hold_win_%0d", i), x_out, win(5));
      check($sformatf("bp_hold_ready_%0d", i), in_ready, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_high", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    model_shift(6);
    check("bp_next_valid", out_valid, 1'b1);
    check("bp_next_win", x_out, win(6));

    // Flush after 3 accepts with sample 99 presented in the flush cycle
    for (int s = 1; s <= 3; s++) push(s);
    in_valid = 1'b1;
    x_in     = {12'd199, 12'd99};
    do_flush(3'd1);
    in_valid = 1'b0;
    check("fl_fill", fill_cnt, 0);
    check("fl_valid", out_valid, 1'b0);
`ifdef CNN_WINDOW_ZERO_FLUSH_EN
    check("fl_x_out_zero", x_out, 0);
`else
    check("fl_x_out_stale", x_out, model_win());
`endif
    for (int s = 1; s <= 5; s++) begin
      push(s);
      check($sformatf("fl_refill_valid_%0d", s), out_valid, s == 5);
    end
    check("fl_refill_win", x_out, win(5));

    // Stride 0 latched on flush behaves as stride 1
    do_flush(3'd0);
    for (int s = 1; s <= 7; s++) begin
      push(s);
      check($sformatf("s0_valid_%0d", s), out_valid, s >= 5);
      if (s >= 5) check($sformatf("s0_win_%0d", s), x_out, win(s));
    end

    // Asynchronous reset between edges while a window is valid
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    check("ar_valid", out_valid, 1'b0);
    check("ar_fill", fill_cnt, 0);
    check("ar_x_out", x_out, 0);
    check("ar_in_ready", in_ready, 1'b1);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int s = 1; s <= 5; s++) begin
      push(s);
      check($sformatf("ar_refill_valid_%0d", s), out_valid, s == 5);
      check($sformatf("ar_refill_fill_%0d", s), fill_cnt, s);
    end
    check("ar_refill_win", x_out, win(5));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
